dmem_ctrl: RTL and testbench

- Data-memory controller sitting directly downstream of the load/store alignment stage.
- Consumes the aligned store word and 4-bit byte mask that stage produces, and owns a word-organised data RAM with per-byte write enables.
- Returns the raw 32-bit read word that the alignment stage then extracts and sign-extends.
- Adds a programmable wait-state FSM and a stall handshake so the core freezes while an access is in flight.

---
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with byte write enables behind a wait-state FSM; optional DMEM_STATS_EN adds load/store counters.
// Latency: stall high for WAIT_CYCLES+1 cycles from request, done pulses one cycle later.
// Backpressure: stall holds the core while an access is in flight; no request is accepted in the DONE cycle.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [30:0] DEPTH_L   = 31'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [29:0] lat_word;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wmask;
    logic        lat_store;
    logic        lat_both;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic        accept;
    logic        acc_fire;
    logic [29:0] acc_word;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic        acc_store;
    logic        acc_both;
    logic        acc_oor;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign req    = load | store;
    assign accept = (state == IDLE) && req;
    assign stall  = !rst && ((state == WAIT) || accept);

    // With no wait states the access happens at the accepting edge, straight from the inputs.
    always_comb begin
        acc_fire  = 1'b0;
        acc_word  = lat_word;
        acc_wdata = lat_wdata;
        acc_wmask = lat_wmask;
        acc_store = lat_store;
        acc_both  = lat_both;
        if (WAIT_CYCLES == 0) begin
            acc_fire  = accept;
            acc_word  = addr[31:2];
            acc_wdata = wdata;
            acc_wmask = wmask;
            acc_store = store;
            acc_both  = load & store;
        end else begin
            acc_fire = (state == WAIT) && (wait_cnt == 4'd0);
        end
    end

    assign acc_oor = {1'b0, acc_word} >= DEPTH_L;
    assign acc_err = acc_oor | acc_both;
    assign acc_idx = acc_word[AW-1:0];

    // RAM survives reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && acc_fire && acc_store && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rdata     <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            lat_word  <= 30'd0;
            lat_wdata <= 32'd0;
            lat_wmask <= 4'd0;
            lat_store <= 1'b0;
            lat_both  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_word  <= addr[31:2];
                        lat_wdata <= wdata;
                        lat_wmask <= wmask;
                        lat_store <= store;
                        lat_both  <= load & store;
                        err       <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= DONE;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
            if (acc_fire) begin
                done  <= 1'b1;
                err   <= acc_err;
                rdata <= (acc_store || acc_oor) ? 32'd0 : mem[acc_idx];
            end
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= 16'd0;
            store_cnt <= 16'd0;
        end else if (acc_fire && !acc_err) begin
            if (acc_store) begin
                if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
            end else begin
                if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: four instances with WAIT_CYCLES 1, 3, 0 and 15, driven by a vector table and directed sequences.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ld [4];
    logic        st [4];
    logic [31:0] ad [4];
    logic [31:0] wd [4];
    logic [3:0]  wm [4];
    logic [31:0] rd [4];
    logic        dn [4];
    logic        sl [4];
    logic        er [4];
`ifdef DMEM_STATS_EN
    logic [15:0] lc [4];
    logic [15:0] sc [4];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .load(ld[0]), .store(st[0]), .addr(ad[0]), .wdata(wd[0]),
        .wmask(wm[0]), .rdata(rd[0]), .done(dn[0]), .stall(sl[0]), .err(er[0])
`ifdef DMEM_STATS_EN
        , .load_cnt(lc[0]), .store_cnt(sc[0])
`endif
    );
    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .load(ld[1]), .store(st[1]), .addr(ad[1]), .wdata(wd[1]),
        .wmask(wm[1]), .rdata(rd[1]), .done(dn[1]), .stall(sl[1]), .err(er[1])
`ifdef DMEM_STATS_EN
        , .load_cnt(lc[1]), .store_cnt(sc[1])
`endif
    );
    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u2 (
        .clk(clk), .rst(rst), .load(ld[2]), .store(st[2]), .addr(ad[2]), .wdata(wd[2]),
        .wmask(wm[2]), .rdata(rd[2]), .done(dn[2]), .stall(sl[2]), .err(er[2])
`ifdef DMEM_STATS_EN
        , .load_cnt(lc[2]), .store_cnt(sc[2])
`endif
    );
    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(15)) u3 (
        .clk(clk), .rst(rst), .load(ld[3]), .store(st[3]), .addr(ad[3]), .wdata(wd[3]),
        .wmask(wm[3]), .rdata(rd[3]), .done(dn[3]), .stall(sl[3]), .err(er[3])
`ifdef DMEM_STATS_EN
        , .load_cnt(lc[3]), .store_cnt(sc[3])
`endif
    );

    typedef struct {
        bit          l;
        bit          s;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  m;
        logic [31:0] exp_r;
        bit          exp_e;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One access: drive at a falling edge, count stall cycles, capture outputs on the done pulse.
    task automatic acc(input int d, input bit l, input bit s, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] m,
                       output logic [31:0] r, output logic e, output int scnt);
        bit ok;
        @(negedge clk);
        ld[d] = l; st[d] = s; ad[d] = a; wd[d] = w; wm[d] = m;
        scnt = 0; ok = 0; r = '0; e = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (sl[d]) scnt++;
            if (dn[d]) begin
                ok = 1; r = rd[d]; e = er[d];
                break;
            end
            @(negedge clk);
        end
        ld[d] = 1'b0; st[d] = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout on dut %0d: got no done, expected done within 40 cycles", d);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          scnt;
        int          exp_ld, exp_st, ndone;

        tv[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tv[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 32'h13,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
        tv[4]  = '{1'b0, 1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tv[5]  = '{1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 32'h0,        32'h01020304, 4'hF, 32'h0,        1'b0};
        tv[7]  = '{1'b0, 1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tv[8]  = '{1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h01020304, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1};
        tv[10] = '{1'b1, 1'b1, 32'h30,       32'h55AA55AA, 4'hF, 32'h0,        1'b1};
        tv[11] = '{1'b1, 1'b0, 32'h30,       32'h0,        4'h0, 32'h55AA55AA, 1'b0};
        tv[12] = '{1'b0, 1'b1, 32'h30,       32'h0,        4'h0, 32'h0,        1'b0};
        tv[13] = '{1'b1, 1'b0, 32'h30,       32'h0,        4'h0, 32'h55AA55AA, 1'b0};
        tv[14] = '{1'b0, 1'b1, 32'hFFC,      32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
        tv[15] = '{1'b1, 1'b0, 32'hFFC,      32'h0,        4'h0, 32'h0BADCAFE, 1'b0};
        tv[16] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

        for (int d = 0; d < 4; d++) begin
            ld[d] = 1'b0; st[d] = 1'b0; ad[d] = '0; wd[d] = '0; wm[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++)
            chk($sformatf("reset_outputs_dut%0d", d), {29'd0, rd[d], dn[d], er[d], sl[d]}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk($sformatf("idle_hold_%0d", i), {29'd0, rd[0], dn[0], er[0], sl[0]}, 64'd0);
        end

        // Vector table on the WAIT_CYCLES=1 instance; the model also tallies expected stats.
        exp_ld = 0; exp_st = 0;
        for (int i = 0; i < 17; i++) begin
            acc(0, tv[i].l, tv[i].s, tv[i].a, tv[i].w, tv[i].m, r, e, scnt);
            chk($sformatf("vec%0d_rdata", i), 64'(r), 64'(tv[i].exp_r));
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(tv[i].exp_e));
            chk($sformatf("vec%0d_stall_cycles", i), 64'(scnt), 64'd2);
            if (!tv[i].exp_e) begin
                if (tv[i].s) exp_st++;
                else exp_ld++;
            end
        end
`ifdef DMEM_STATS_EN
        chk("stats_load_cnt", 64'(lc[0]), 64'(exp_ld));
        chk("stats_store_cnt", 64'(sc[0]), 64'(exp_st));
`endif

        // Wait-state sweep: stall length is WAIT_CYCLES+1.
        acc(2, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, r, e, scnt);
        chk("w0_store_stall", 64'(scnt), 64'd1);
        acc(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, r, e, scnt);
        chk("w0_load_stall", 64'(scnt), 64'd1);
        chk("w0_load_rdata", 64'(r), 64'hA5A5A5A5);
        acc(3, 1'b0, 1'b1, 32'h44, 32'h13579BDF, 4'hF, r, e, scnt);
        chk("w15_store_stall", 64'(scnt), 64'd16);
        acc(3, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, r, e, scnt);
        chk("w15_load_stall", 64'(scnt), 64'd16);
        chk("w15_load_rdata", 64'(r), 64'h13579BDF);

        // Held load on the zero-wait instance: done every other cycle, never back to back.
        @(negedge clk);
        ld[2] = 1'b1; ad[2] = 32'h40;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk($sformatf("b2b_done_%0d", i), 64'(dn[2]), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        ld[2] = 1'b0;

        // Reset during WAIT must abandon the store.
        acc(1, 1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF, r, e, scnt);
        chk("w3_store_stall", 64'(scnt), 64'd4);
        @(negedge clk);
        st[1] = 1'b1; ad[1] = 32'h8; wd[1] = 32'hCAFEF00D; wm[1] = 4'hF;
        @(negedge clk); #1;
        chk("midrst_in_wait_stall", 64'(sl[1]), 64'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_during_reset", {62'd0, sl[1], dn[1]}, 64'd0);
        rst = 1'b0; st[1] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (dn[1]) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        acc(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, r, e, scnt);
        chk("midrst_old_data", 64'(r), 64'h12345678);
        chk("midrst_load_err", 64'(e), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
